// File: rtl/li_credit_shell_if.sv
// Operand/result handshake plus core issue/return port bundle for the credit shell.
// The shell uses the slave view; whoever feeds it and models the core uses master.
interface li_credit_shell_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 1
);
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_issue;
    logic [WIDTH-1:0] core_result;

    modport master (
        output in_a, in_b, in_tag, in_valid, out_ready, core_result,
        input  in_ready, out_result, out_tag, out_valid, core_a, core_b, core_issue
    );

    modport slave (
        input  in_a, in_b, in_tag, in_valid, out_ready, core_result,
        output in_ready, out_result, out_tag, out_valid, core_a, core_b, core_issue
    );
endinterface

// File: rtl/li_credit_shell.sv
// Latency-insensitive shell around a free-running fixed-latency core: credits bound
// outstanding work to DEPTH so every core result always has a FIFO slot waiting.
module li_credit_shell #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 1,
    parameter int LATENCY = 1,
    parameter int DEPTH   = LATENCY + 3
) (
    input  logic              clk,
    input  logic              reset,
    li_credit_shell_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                           acc, pop, wr;
    logic [CW-1:0]                  outstanding, fifo_count;
    logic [PW-1:0]                  head, tail;
    logic [LATENCY:0]               vld_pipe;
    logic [LATENCY:0][TAG_W-1:0]    tag_pipe;
    logic [WIDTH-1:0]               res_mem [DEPTH];
    logic [TAG_W-1:0]               tag_mem [DEPTH];

    // Pointer wrap written explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready looks only at registered credit state, never at out_ready.
    assign bus.in_ready   = (outstanding < CW'(DEPTH)) && !reset;
    assign acc            = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = (fifo_count != '0);
    assign pop            = bus.out_valid && bus.out_ready;
    assign wr             = vld_pipe[LATENCY];
    assign bus.core_issue = vld_pipe[0];
    assign bus.out_result = res_mem[head];
    assign bus.out_tag    = tag_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe    <= '0;
            bus.core_a  <= '0;
            bus.core_b  <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            // Bit 0 is core_issue; bit LATENCY marks core_result as ours this cycle.
            vld_pipe <= {vld_pipe[LATENCY-1:0], acc};
            if (acc) begin
                bus.core_a <= bus.in_a;
                bus.core_b <= bus.in_b;
            end
            if (wr)
                tail <= nxt(tail);
            if (pop)
                head <= nxt(head);
            if (acc && !pop)
                outstanding <= outstanding + 1'b1;
            else if (!acc && pop)
                outstanding <= outstanding - 1'b1;
            if (wr && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (!wr && pop)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Tags ride beside the valid bits; stale tags are harmless since wr qualifies them.
    always_ff @(posedge clk) begin
        tag_pipe <= {tag_pipe[LATENCY-1:0], bus.in_tag};
        if (wr) begin
            res_mem[tail] <= bus.core_result;
            tag_mem[tail] <= tag_pipe[LATENCY];
        end
    end
endmodule

// File: tb/tb_li_credit_shell.sv
// Bench for li_credit_shell: three configurations, delay-line core models and a
// queue scoreboard of {a+b, tag} in acceptance order.
module tb_li_credit_shell;
    typedef logic [32:0] ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    ent_t exp0[$];
    ent_t exp1[$];
    ent_t exp2[$];

    always #5 clk = ~clk;

    li_credit_shell_if #(.WIDTH(32), .TAG_W(1)) b0 ();
    li_credit_shell_if #(.WIDTH(32), .TAG_W(1)) b1 ();
    li_credit_shell_if #(.WIDTH(32), .TAG_W(1)) b2 ();

    li_credit_shell #(.WIDTH(32), .TAG_W(1), .LATENCY(3), .DEPTH(6)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    li_credit_shell #(.WIDTH(32), .TAG_W(1), .LATENCY(2), .DEPTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    li_credit_shell #(.WIDTH(32), .TAG_W(1), .LATENCY(4), .DEPTH(7)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    // Core models: pure LATENCY-cycle delay of core_a+core_b.
    logic [31:0] p0 [3];
    logic [31:0] p1 [2];
    logic [31:0] p2 [4];
    always @(posedge clk) begin
        p0[0] <= b0.core_a + b0.core_b;
        p1[0] <= b1.core_a + b1.core_b;
        p2[0] <= b2.core_a + b2.core_b;
        for (int i = 1; i < 3; i++) p0[i] <= p0[i-1];
        for (int i = 1; i < 2; i++) p1[i] <= p1[i-1];
        for (int i = 1; i < 4; i++) p2[i] <= p2[i-1];
    end
    assign b0.core_result = p0[2];
    assign b1.core_result = p1[1];
    assign b2.core_result = p2[3];

    // A core write must never meet a full FIFO.
    always @(negedge clk) begin
        if (!reset) begin
            if ((dut0.wr && dut0.fifo_count == 6) || (dut1.wr && dut1.fifo_count == 1) ||
                (dut2.wr && dut2.fifo_count == 7)) begin
                n_err++;
                $display("FAIL fifo_overflow: write into full FIFO at %0t", $time);
            end
        end
    end

    // One cycle on instance u: drive at negedge, observe mid-cycle, keep the scoreboard.
    task automatic xfer(input int u, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic t, input logic r, output logic acc, output logic pop,
                        output ent_t got, output ent_t want);
        @(negedge clk);
        want = 'x;
        case (u)
            0: begin
                b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.in_tag = t; b0.out_ready = r;
                #1;
                acc = b0.in_valid && b0.in_ready;
                pop = b0.out_valid && b0.out_ready;
                got = {b0.out_result, b0.out_tag};
                if (acc) exp0.push_back({a + b, t});
                if (pop && exp0.size() != 0) want = exp0.pop_front();
            end
            1: begin
                b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_tag = t; b1.out_ready = r;
                #1;
                acc = b1.in_valid && b1.in_ready;
                pop = b1.out_valid && b1.out_ready;
                got = {b1.out_result, b1.out_tag};
                if (acc) exp1.push_back({a + b, t});
                if (pop && exp1.size() != 0) want = exp1.pop_front();
            end
            default: begin
                b2.in_valid = v; b2.in_a = a; b2.in_b = b; b2.in_tag = t; b2.out_ready = r;
                #1;
                acc = b2.in_valid && b2.in_ready;
                pop = b2.out_valid && b2.out_ready;
                got = {b2.out_result, b2.out_tag};
                if (acc) exp2.push_back({a + b, t});
                if (pop && exp2.size() != 0) want = exp2.pop_front();
            end
        endcase
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_chk++;
            if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0 || b0.core_issue !== 1'b0 ||
                b1.in_ready !== 1'b0 || b2.in_ready !== 1'b0)
                begin n_err++; $display("FAIL reset_hold: in_ready=%b out_valid=%b core_issue=%b, need 0 0 0",
                                        b0.in_ready, b0.out_valid, b0.core_issue); end
            n_chk++;
            if (b0.core_a !== 32'd0 || b0.core_b !== 32'd0)
                begin n_err++; $display("FAIL reset_core_ops: core_a=%h core_b=%h, need 0", b0.core_a, b0.core_b); end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b2.in_ready !== 1'b1)
            begin n_err++; $display("FAIL reset_release: in_ready=%b%b%b, need 111", b0.in_ready, b1.in_ready, b2.in_ready); end
    endtask

    task automatic test_single();
        logic acc, pop; ent_t got, want;
        xfer(0, 1, 32'd5, 32'd7, 1'b1, 1'b0, acc, pop, got, want);
        n_chk++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: acc=%b, need 1", acc); end
        for (int j = 1; j <= 5; j++) begin
            xfer(0, 0, 0, 0, 0, 0, acc, pop, got, want);
            n_chk++;
            if (b0.core_issue !== (j == 1))
                begin n_err++; $display("FAIL single_issue: k+%0d core_issue=%b, need %b", j, b0.core_issue, j == 1); end
            n_chk++;
            if (b0.out_valid !== (j == 5))
                begin n_err++; $display("FAIL single_latency: k+%0d out_valid=%b, need %b", j, b0.out_valid, j == 5); end
            if (j == 5) begin
                n_chk++;
                if (got !== {32'd12, 1'b1})
                    begin n_err++; $display("FAIL single_result: got %h, need %h", got, {32'd12, 1'b1}); end
            end
        end
        xfer(0, 0, 0, 0, 0, 1, acc, pop, got, want);
        n_chk++;
        if (pop !== 1'b1 || got !== want)
            begin n_err++; $display("FAIL single_pop: pop=%b got %h, need %h", pop, got, want); end
        xfer(0, 0, 0, 0, 0, 0, acc, pop, got, want);
        n_chk++;
        if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: out_valid=%b, need 0", b0.out_valid); end
    endtask

    task automatic test_stream();
        logic acc, pop; ent_t got, want;
        int sent = 0, npop = 0, first = -1, last = -1, drops = 0, bad = 0;
        for (int c = 0; c < 200 && npop < 100; c++) begin
            xfer(0, sent < 100, sent, 2 * sent, sent[0], 1, acc, pop, got, want);
            if (sent < 100 && !acc) drops++;
            if (acc) sent++;
            if (pop) begin
                if (got !== want) begin
                    bad++;
                    $display("FAIL stream_result: pop %0d got %h, need %h", npop, got, want);
                end
                if (first < 0) first = c;
                last = c;
                npop++;
            end
        end
        n_chk++;
        if (bad != 0) n_err++;
        n_chk++;
        if (drops != 0) begin n_err++; $display("FAIL stream_ready: in_ready fell %0d times, need 0", drops); end
        n_chk++;
        if (npop != 100 || last - first != 99)
            begin n_err++; $display("FAIL stream_rate: %0d results over %0d cycles, need 100 over 100", npop, last - first + 1); end
    endtask

    task automatic test_backpressure();
        logic acc, pop; ent_t got, want;
        int nacc = 0, bad = 0;
        for (int c = 0; c < 12; c++) begin
            xfer(0, 1, $urandom, $urandom, 1'($urandom), 0, acc, pop, got, want);
            if (acc) nacc++;
        end
        n_chk++;
        if (nacc != 6 || b0.in_ready !== 1'b0)
            begin n_err++; $display("FAIL bp_credits: accepts=%0d in_ready=%b, need 6 and 0", nacc, b0.in_ready); end
        n_chk++;
        if (b0.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_resident: out_valid=%b, need 1", b0.out_valid); end
        xfer(0, 0, 0, 0, 0, 1, acc, pop, got, want);
        n_chk++;
        if (pop !== 1'b1 || got !== want)
            begin n_err++; $display("FAIL bp_pop: pop=%b got %h, need %h", pop, got, want); end
        xfer(0, 0, 0, 0, 0, 0, acc, pop, got, want);
        n_chk++;
        if (b0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_credit_return: in_ready=%b, need 1", b0.in_ready); end
        for (int c = 0; c < 20; c++) begin
            xfer(0, 0, 0, 0, 0, 1, acc, pop, got, want);
            if (pop && got !== want) begin bad++; $display("FAIL bp_drain: got %h, need %h", got, want); end
        end
        n_chk++;
        if (bad != 0 || exp0.size() != 0)
            begin n_err++; $display("FAIL bp_lost: %0d wrong, %0d unreturned, need 0 0", bad, exp0.size()); end
    endtask

    task automatic test_random();
        logic acc, pop; ent_t got, want;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            xfer(0, ($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), ($urandom % 3) != 0,
                 acc, pop, got, want);
            if (pop && got !== want) begin bad++; $display("FAIL random_result: got %h, need %h", got, want); end
        end
        for (int c = 0; c < 30; c++) begin
            xfer(0, 0, 0, 0, 0, 1, acc, pop, got, want);
            if (pop && got !== want) begin bad++; $display("FAIL random_drain: got %h, need %h", got, want); end
        end
        n_chk++;
        if (bad != 0 || exp0.size() != 0)
            begin n_err++; $display("FAIL random_order: %0d wrong, %0d unreturned, need 0 0", bad, exp0.size()); end
    endtask

    task automatic test_reduced_depth();
        logic acc, pop; ent_t got, want;
        int prev = -1, bad = 0, gaps = 0, nacc = 0;
        for (int c = 0; c < 40; c++) begin
            xfer(1, 1, $urandom, $urandom, 1'($urandom), 1, acc, pop, got, want);
            if (acc) begin
                if (prev >= 0 && c - prev != 5) begin
                    gaps++;
                    $display("FAIL reduced_spacing: accept gap %0d, need 5", c - prev);
                end
                prev = c;
                nacc++;
            end
            if (pop && got !== want) begin bad++; $display("FAIL reduced_result: got %h, need %h", got, want); end
        end
        for (int c = 0; c < 10; c++) begin
            xfer(1, 0, 0, 0, 0, 1, acc, pop, got, want);
            if (pop && got !== want) begin bad++; $display("FAIL reduced_result: got %h, need %h", got, want); end
        end
        n_chk++;
        if (gaps != 0 || nacc != 8) begin n_err++; $display("FAIL reduced_rate: %0d accepts, need 8", nacc); end
        n_chk++;
        if (bad != 0 || exp1.size() != 0)
            begin n_err++; $display("FAIL reduced_lost: %0d wrong, %0d unreturned, need 0 0", bad, exp1.size()); end
    endtask

    task automatic test_reset_midflight();
        logic acc, pop; ent_t got, want;
        int nacc = 0, ghosts = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(2, 1, $urandom, $urandom, 1'($urandom), 1, acc, pop, got, want);
            if (acc) nacc++;
        end
        n_chk++;
        if (nacc != 3) begin n_err++; $display("FAIL midflight_accept: accepts=%0d, need 3", nacc); end
        @(negedge clk);
        b2.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp2.delete();
        for (int c = 0; c < 10; c++) begin
            xfer(2, 0, 0, 0, 0, 1, acc, pop, got, want);
            if (b2.out_valid !== 1'b0) ghosts++;
        end
        n_chk++;
        if (ghosts != 0) begin n_err++; $display("FAIL midflight_discard: out_valid seen %0d cycles, need 0", ghosts); end
        xfer(2, 1, 32'd1, 32'd1, 1'b0, 0, acc, pop, got, want);
        n_chk++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL midflight_new_accept: acc=%b, need 1", acc); end
        for (int j = 1; j <= 6; j++) begin
            xfer(2, 0, 0, 0, 0, 0, acc, pop, got, want);
            n_chk++;
            if (b2.out_valid !== (j == 6))
                begin n_err++; $display("FAIL midflight_latency: k+%0d out_valid=%b, need %b", j, b2.out_valid, j == 6); end
        end
        n_chk++;
        if (got !== {32'd2, 1'b0}) begin n_err++; $display("FAIL midflight_result: got %h, need %h", got, {32'd2, 1'b0}); end
        xfer(2, 0, 0, 0, 0, 1, acc, pop, got, want);
        n_chk++;
        if (pop !== 1'b1 || got !== want)
            begin n_err++; $display("FAIL midflight_pop: pop=%b got %h, need %h", pop, got, want); end
    endtask

    initial begin
        b0.in_valid = 0; b0.in_a = 0; b0.in_b = 0; b0.in_tag = 0; b0.out_ready = 0;
        b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.in_tag = 0; b1.out_ready = 0;
        b2.in_valid = 0; b2.in_a = 0; b2.in_b = 0; b2.in_tag = 0; b2.out_ready = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_reduced_depth();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
